sequential_multiplier_hs: RTL and testbench

//   Parametrised shift-and-add multiplier, one multiplier bit per clock, with a

---
 rtl/sequential_multiplier_hs_if.sv | 45 ++++
 rtl/sequential_multiplier_hs.sv | 138 +++++++++++++
 tb/tb_sequential_multiplier_hs.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequential_multiplier_hs_if.sv
// Handshake bundle for sequential_multiplier_hs: operand request channel
// (producer -> multiplier) and result channel (multiplier -> consumer).
// The master modport is the producer/consumer side, slave is the multiplier.
interface sequential_multiplier_hs_if #(
   parameter int BITS = 8
);
   // Request channel
   logic              i_valid;
   logic              o_ready;
   logic              i_signed;
   logic [BITS-1:0]   i_multiplicand;
   logic [BITS-1:0]   i_multiplier;

   // Result channel
   logic              o_valid;
   logic              i_ready;
   logic [2*BITS-1:0] o_product;

   // Status
   logic              o_busy;

   modport master (
      output i_valid,
      output i_signed,
      output i_multiplicand,
      output i_multiplier,
      output i_ready,
      input  o_ready,
      input  o_valid,
      input  o_product,
      input  o_busy
   );

   modport slave (
      input  i_valid,
      input  i_signed,
      input  i_multiplicand,
      input  i_multiplier,
      input  i_ready,
      output o_ready,
      output o_valid,
      output o_product,
      output o_busy
   );
endinterface

// File: rtl/sequential_multiplier_hs.sv
// Shift-and-add multiplier, one multiplier bit per clock, with valid/ready
// handshakes on the operand and result sides. Signed operations are handled
// by multiplying magnitudes and negating the finished product when the
// operand signs differ. The result is held in DONE until the consumer takes
// it; a new operation may be accepted on that same edge.
module sequential_multiplier_hs #(
   parameter  int BITS  = 8,
   localparam int CNT_W = $clog2(BITS) + 1
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   sequential_multiplier_hs_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;

   // Datapath registers
   logic [2*BITS-1:0] mcand_q;     // multiplicand magnitude, shifted left each RUN cycle
   logic [BITS-1:0]   mplier_q;    // multiplier magnitude, shifted right each RUN cycle
   logic [2*BITS-1:0] acc_q;       // partial-product accumulator
   logic              neg_q;       // result must be negated at the end
   logic [CNT_W-1:0]  cnt_q;       // RUN iteration index, 0..BITS-1
   logic [2*BITS-1:0] product_q;   // registered result presented to the consumer

   // Combinational helpers
   logic [BITS-1:0]   a_mag;
   logic [BITS-1:0]   b_mag;
   logic              neg_in;
   logic [2*BITS-1:0] acc_sum;
   logic              last_iter;
   logic              accept;
   logic              ready;

   // Magnitudes and result sign of the operands currently on the bus; only
   // used on the accept edge. |-2^(BITS-1)| still fits in BITS unsigned bits.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
      a_mag  = bus.i_multiplicand;
      b_mag  = bus.i_multiplier;
      neg_in = 1'b0;
      if (bus.i_signed) begin
         if (bus.i_multiplicand[BITS-1]) begin
            a_mag = -bus.i_multiplicand;
         end
         if (bus.i_multiplier[BITS-1]) begin
            b_mag = -bus.i_multiplier;
         end
         neg_in = bus.i_multiplicand[BITS-1] ^ bus.i_multiplier[BITS-1];
      end
   end

   // One shift-and-add step; the adder carry-out beyond 2*BITS is dropped.
   always_comb begin
      acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
      last_iter = (cnt_q == CNT_W'(BITS - 1));
      accept    = bus.i_valid & ready;
   end

   // State register.
   always_ff @(posedge i_clock) begin
      // NOTE: clocked state is always written with non-blocking assignments so every register samples pre-edge values.
      if (i_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (last_iter) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.i_ready) begin
               state_next = bus.i_valid ? S_RUN : S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from state; o_ready also looks through i_ready in DONE
   // so a finished result can be retired and a new operation started together.
   always_comb begin
      ready         = (state == S_IDLE) | ((state == S_DONE) & bus.i_ready);
      bus.o_ready   = ready;
      bus.o_valid   = (state == S_DONE);
      bus.o_busy    = (state == S_RUN);
      bus.o_product = product_q;
   end

   // Datapath: load magnitudes on accept, iterate in RUN, publish the signed
   // result on the RUN->DONE edge. o_product is untouched at all other times.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else if (accept) begin
         mcand_q  <= {{BITS{1'b0}}, a_mag};
         mplier_q <= b_mag;
         acc_q    <= '0;
         neg_q    <= neg_in;
         cnt_q    <= '0;
      end else if (state == S_RUN) begin
         acc_q    <= acc_sum;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CNT_W'(1);
         if (last_iter) begin
            product_q <= neg_q ? -acc_sum : acc_sum;
         end
      end
   end

endmodule

// File: tb/tb_sequential_multiplier_hs.sv
// Self-checking bench for sequential_multiplier_hs at BITS = 8 (directed
// table, back-pressure, back-to-back, reset and a random handshake stream),
// BITS = 4 (exhaustive) and BITS = 16 (random).
module tb_sequential_multiplier_hs;

   logic i_clock;
   logic i_reset;

   int n_vec  = 0;
   int n_miss = 0;

   sequential_multiplier_hs_if #(.BITS(8))  m8  ();
   sequential_multiplier_hs_if #(.BITS(4))  m4  ();
   sequential_multiplier_hs_if #(.BITS(16)) m16 ();

   sequential_multiplier_hs #(.BITS(8))  dut8  (.i_clock(i_clock), .i_reset(i_reset), .bus(m8));
   sequential_multiplier_hs #(.BITS(4))  dut4  (.i_clock(i_clock), .i_reset(i_reset), .bus(m4));
   sequential_multiplier_hs #(.BITS(16)) dut16 (.i_clock(i_clock), .i_reset(i_reset), .bus(m16));

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic        s;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] want;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clock);
      #1;
   endtask

   // Reference product: sign-extend operands as plain integers, multiply,
   // keep the low 2*bits bits.
   function automatic logic [31:0] ref_mul(input int bits, input logic s,
                                           input logic [15:0] a, input logic [15:0] b);
      longint     av;
      longint     bv;
      longint     p;
      logic [63:0] mask;
      av = longint'(a);
      bv = longint'(b);
      if (s && a[bits-1]) av = av - (longint'(1) << bits);
      if (s && b[bits-1]) bv = bv - (longint'(1) << bits);
      p    = av * bv;
      mask = (64'd1 << (2 * bits)) - 64'd1;
      return 32'(64'(p) & mask);
   endfunction

   // One operation on the 8-bit instance with i_ready held high, from IDLE.
   task automatic op8(input string name, input logic s, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] want);
      int lat;
      m8.i_signed       = s;
      m8.i_multiplicand = a;
      m8.i_multiplier   = b;
      m8.i_valid        = 1'b1;
      #1;
      check({name, " ready"}, 32'(m8.o_ready), 32'd1);
      step();
      m8.i_valid = 1'b0;
      lat = 0;
      while (!m8.o_valid && lat < 40) begin
         step();
         lat++;
      end
      check({name, " latency"}, 32'(lat), 32'd8);
      check({name, " product"}, 32'(m8.o_product), 32'(want));
      step();
      check({name, " back to idle"}, 32'(m8.o_valid), 32'd0);
   endtask

   task automatic op4(input logic s, input logic [3:0] a, input logic [3:0] b);
      int lat;
      m4.i_signed       = s;
      m4.i_multiplicand = a;
      m4.i_multiplier   = b;
      m4.i_valid        = 1'b1;
      step();
      m4.i_valid = 1'b0;
      lat = 0;
      while (!m4.o_valid && lat < 40) begin
         step();
         lat++;
      end
      check("b4 latency", 32'(lat), 32'd4);
      check("b4 product", 32'(m4.o_product), ref_mul(4, s, 16'(a), 16'(b)));
      step();
   endtask

   task automatic op16(input logic s, input logic [15:0] a, input logic [15:0] b);
      int lat;
      m16.i_signed       = s;
      m16.i_multiplicand = a;
      m16.i_multiplier   = b;
      m16.i_valid        = 1'b1;
      step();
      m16.i_valid = 1'b0;
      lat = 0;
      while (!m16.o_valid && lat < 60) begin
         step();
         lat++;
      end
      check("b16 latency", 32'(lat), 32'd16);
      check("b16 product", m16.o_product, ref_mul(16, s, a, b));
      step();
   endtask

   initial begin
      tbl[0] = '{"u 200*250",   1'b0, 8'd200,  8'd250,  16'd50000};
      tbl[1] = '{"s -128*-128", 1'b1, 8'h80,   8'h80,   16'h4000};
      tbl[2] = '{"s -1*127",    1'b1, 8'hFF,   8'h7F,   16'hFF81};
      tbl[3] = '{"s -5*0",      1'b1, 8'hFB,   8'h00,   16'h0000};
      tbl[4] = '{"s -128*127",  1'b1, 8'h80,   8'h7F,   16'hC080};
      tbl[5] = '{"s -1*-1",     1'b1, 8'hFF,   8'hFF,   16'h0001};
      tbl[6] = '{"u 255*255",   1'b0, 8'hFF,   8'hFF,   16'd65025};
      tbl[7] = '{"u 0*77",      1'b0, 8'd0,    8'd77,   16'd0};

      m8.i_valid  = 1'b0; m8.i_ready  = 1'b1; m8.i_signed  = 1'b0;
      m8.i_multiplicand  = '0; m8.i_multiplier  = '0;
      m4.i_valid  = 1'b0; m4.i_ready  = 1'b1; m4.i_signed  = 1'b0;
      m4.i_multiplicand  = '0; m4.i_multiplier  = '0;
      m16.i_valid = 1'b0; m16.i_ready = 1'b1; m16.i_signed = 1'b0;
      m16.i_multiplicand = '0; m16.i_multiplier = '0;

      i_reset = 1'b1;
      repeat (3) step();
      i_reset = 1'b0;

      // Reset state
      check("reset o_valid",   32'(m8.o_valid),   32'd0);
      check("reset o_busy",    32'(m8.o_busy),    32'd0);
      check("reset o_product", 32'(m8.o_product), 32'd0);
      check("reset o_ready",   32'(m8.o_ready),   32'd1);

      // Directed table
      for (int i = 0; i < 8; i++) begin
         op8(tbl[i].name, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].want);
      end

      // Back-pressure: result held 5 cycles, a pending request must wait
      begin : back_pressure
         int lat;
         m8.i_ready = 1'b0;
         m8.i_signed = 1'b0; m8.i_multiplicand = 8'd13; m8.i_multiplier = 8'd11;
         m8.i_valid = 1'b1;
         step();
         m8.i_multiplicand = 8'd9; m8.i_multiplier = 8'd9;
         m8.i_valid = 1'b0;
         lat = 0;
         while (!m8.o_valid && lat < 40) begin
            step();
            lat++;
         end
         check("bp latency", 32'(lat), 32'd8);
         m8.i_valid = 1'b1;
         for (int k = 0; k < 5; k++) begin
            #1;
            check("bp o_valid held",   32'(m8.o_valid),   32'd1);
            check("bp o_product held", 32'(m8.o_product), 32'd143);
            check("bp o_ready low",    32'(m8.o_ready),   32'd0);
            step();
         end
         m8.i_ready = 1'b1;
         #1;
         check("bp release ready", 32'(m8.o_ready), 32'd1);
         step();
         m8.i_valid = 1'b0;
         check("bp taken", 32'(m8.o_valid), 32'd0);
         check("bp next op running", 32'(m8.o_busy), 32'd1);
         lat = 0;
         while (!m8.o_valid && lat < 40) begin
            step();
            lat++;
         end
         check("bp held op latency", 32'(lat), 32'd8);
         check("bp held op product", 32'(m8.o_product), 32'd81);
         step();
      end

      // Back-to-back with i_valid held high
      begin : back_to_back
         logic [7:0]  ba[3];
         logic [7:0]  bb[3];
         logic [15:0] bw[3];
         int k;
         int cyc;
         int last;
         ba[0] = 8'd3;   bb[0] = 8'd4;   bw[0] = 16'd12;
         ba[1] = 8'd7;   bb[1] = 8'd9;   bw[1] = 16'd63;
         ba[2] = 8'd255; bb[2] = 8'd255; bw[2] = 16'd65025;
         m8.i_signed = 1'b0;
         m8.i_multiplicand = ba[0]; m8.i_multiplier = bb[0];
         m8.i_valid = 1'b1;
         step();
         m8.i_multiplicand = ba[1]; m8.i_multiplier = bb[1];
         k = 0; cyc = 0; last = 0;
         while (k < 3 && cyc < 60) begin
            step();
            cyc++;
            if (m8.o_valid) begin
               check("b2b product", 32'(m8.o_product), 32'(bw[k]));
               check("b2b spacing", 32'(cyc - last), (k == 0) ? 32'd8 : 32'd9);
               last = cyc;
               k++;
               step();
               cyc++;
               if (k < 3) check("b2b no idle gap", 32'(m8.o_busy), 32'd1);
               if (k + 1 < 3) begin
                  m8.i_multiplicand = ba[k+1]; m8.i_multiplier = bb[k+1];
               end else begin
                  m8.i_valid = 1'b0;
               end
            end
         end
         m8.i_valid = 1'b0;
         check("b2b all results", 32'(k), 32'd3);
      end

      // Reset in the middle of RUN
      m8.i_signed = 1'b0; m8.i_multiplicand = 8'd100; m8.i_multiplier = 8'd3;
      m8.i_valid = 1'b1;
      step();
      m8.i_valid = 1'b0;
      repeat (4) step();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      check("mid-run reset o_valid",   32'(m8.o_valid),   32'd0);
      check("mid-run reset o_busy",    32'(m8.o_busy),    32'd0);
      check("mid-run reset o_product", 32'(m8.o_product), 32'd0);
      check("mid-run reset o_ready",   32'(m8.o_ready),   32'd1);
      op8("after reset 6*7", 1'b0, 8'd6, 8'd7, 16'd42);

      // Random handshake stream against a one-outstanding-op model
      begin : stream
         logic        pending;
         int          age;
         logic [15:0] want;
         int          sent;
         int          taken;
         logic        exp_v;
         logic        exp_r;
         logic        acc;
         logic        tk;
         pending = 1'b0; age = 0; want = '0; sent = 0; taken = 0;
         m8.i_valid = 1'b0;
         for (int c = 0; c < 1500 && taken < 40; c++) begin
            if (!m8.i_valid && sent < 40 && $urandom_range(0, 2) == 0) begin
               m8.i_signed       = 1'($urandom_range(0, 1));
               m8.i_multiplicand = 8'($urandom);
               m8.i_multiplier   = 8'($urandom);
               m8.i_valid        = 1'b1;
            end
            m8.i_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_v = pending && (age >= 8);
            exp_r = !pending || (exp_v && m8.i_ready);
            check("stream o_valid", 32'(m8.o_valid), 32'(exp_v));
            check("stream o_ready", 32'(m8.o_ready), 32'(exp_r));
            if (exp_v) check("stream o_product", 32'(m8.o_product), 32'(want));
            tk  = exp_v && m8.i_ready;
            acc = m8.i_valid && exp_r;
            step();
            if (pending) age++;
            if (tk) begin
               pending = 1'b0;
               taken++;
            end
            if (acc) begin
               pending = 1'b1;
               age     = 0;
               sent++;
               want = 16'(ref_mul(8, m8.i_signed, 16'(m8.i_multiplicand), 16'(m8.i_multiplier)));
               m8.i_valid = 1'b0;
            end
         end
         m8.i_ready = 1'b1;
         check("stream results retired", 32'(taken), 32'd40);
      end

      // BITS = 4 exhaustive, both modes
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               op4(1'(s), 4'(a), 4'(b));
            end
         end
      end

      // BITS = 16 random, both modes, plus the extreme negative corner
      op16(1'b1, 16'h8000, 16'h8000);
      op16(1'b0, 16'hFFFF, 16'hFFFF);
      for (int i = 0; i < 100; i++) begin
         op16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
